// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the I/D caches, the memory-port arbiter and main memory.
// Latency: none, this is wiring only.
// Backpressure: none here; the req/gnt and mem_req/mem_ready pairs carry it.
//
// Signal groups:
//   I side  : i_req, i_addr            -> arbiter;  i_gnt, i_done, i_rdata  <- arbiter
//   D side  : d_req, d_we, d_addr,
//             d_wdata                  -> arbiter;  d_gnt, d_done, d_rdata  <- arbiter
//   memory  : mem_req, mem_we, mem_addr,
//             mem_wdata                <- arbiter;  mem_ready, mem_rvalid,
//                                                   mem_rdata               -> arbiter
// Modports: slave = the arbiter's view, master = the surrounding environment's view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_done;
    logic [DATA_W-1:0] i_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_done;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  i_req, i_addr,
        output i_gnt, i_done, i_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_done, d_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rvalid, mem_rdata
    );

    modport master (
        output i_req, i_addr,
        input  i_gnt, i_done, i_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_done, d_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one main-memory port between I-cache refills and D-cache loads/stores, one transaction at a time.
// Latency (zero-wait memory): gnt 1 cycle after req is sampled, write done at +2, read done at +3.
// Backpressure: requesters hold req until gnt; mem_req is held until mem_ready; a silent memory is
//   abandoned after TIMEOUT cycles in REQ or RESP with an err pulse and a done to the owner.
//
// Ports:
//   clock  - rising-edge clock
//   reset  - asynchronous active-low reset
//   bus    - mem_port_arbiter_if.slave: I/D request sides and the memory side
//   busy   - high whenever a transaction is in flight (state != IDLE)
//   err    - one-cycle pulse when a transaction is aborted on timeout
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int D_PRIORITY = 1,
    parameter int STARVE_LIM = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic                clock,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus,
    output logic                busy,
    output logic                err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        SIDE_I = 1'b0,
        SIDE_D = 1'b1
    } side_t;

    localparam int SC_W = $clog2(STARVE_LIM + 1);
    localparam int WC_W = $clog2(TIMEOUT + 1);
    localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIM);
    // The abort decision is taken on the edge that would make wait_cnt reach TIMEOUT, so that
    // err/done/mem_req-low are all visible in the cycle where the count equals TIMEOUT.
    localparam logic [WC_W-1:0] WAIT_LAST  = WC_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    side_t             owner_q, owner_d;
    side_t             rr_last_q, rr_last_d;
    logic [SC_W-1:0]   starve_q, starve_d;
    logic [WC_W-1:0]   wait_q, wait_d;

    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              latch_en;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;

    logic              i_gnt_q, i_gnt_d;
    logic              d_gnt_q, d_gnt_d;
    logic              i_done_q, i_done_d;
    logic              d_done_q, d_done_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    logic              pick_d;

    // Winner selection, only consumed in IDLE.
    always_comb begin
        pick_d = 1'b0;
        if (bus.d_req && !bus.i_req) begin
            pick_d = 1'b1;
        end else if (bus.d_req && bus.i_req) begin
            if (D_PRIORITY != 0) begin
                pick_d = (starve_q != STARVE_MAX);
            end else begin
                pick_d = (rr_last_q == SIDE_I);
            end
        end
    end

    // Next state and registered-output values.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_last_d = rr_last_q;
        wait_d    = wait_q;
        latch_en  = 1'b0;
        lat_we    = 1'b0;
        lat_addr  = bus.i_addr;
        lat_wdata = '0;
        i_gnt_d   = 1'b0;
        d_gnt_d   = 1'b0;
        i_done_d  = 1'b0;
        d_done_d  = 1'b0;
        err_d     = 1'b0;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;

        case (state_q)
            IDLE: begin
                if (bus.i_req || bus.d_req) begin
                    state_d  = REQ;
                    wait_d   = '0;
                    latch_en = 1'b1;
                    if (pick_d) begin
                        owner_d   = SIDE_D;
                        rr_last_d = SIDE_D;
                        d_gnt_d   = 1'b1;
                        lat_we    = bus.d_we;
                        lat_addr  = bus.d_addr;
                        lat_wdata = bus.d_wdata;
                    end else begin
                        owner_d   = SIDE_I;
                        rr_last_d = SIDE_I;
                        i_gnt_d   = 1'b1;
                    end
                end
            end

            REQ: begin
                wait_d = wait_q + WC_W'(1);
                if (bus.mem_ready) begin
                    if (we_q) begin
                        // A store is complete once memory accepts it.
                        state_d = IDLE;
                        if (owner_q == SIDE_D) d_done_d = 1'b1;
                        else                   i_done_d = 1'b1;
                    end else begin
                        state_d = RESP;
                        wait_d  = '0;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                    if (owner_q == SIDE_D) d_done_d = 1'b1;
                    else                   i_done_d = 1'b1;
                end
            end

            RESP: begin
                wait_d = wait_q + WC_W'(1);
                if (bus.mem_rvalid) begin
                    state_d = IDLE;
                    if (owner_q == SIDE_D) begin
                        d_done_d  = 1'b1;
                        d_rdata_d = bus.mem_rdata;
                    end else begin
                        i_done_d  = 1'b1;
                        i_rdata_d = bus.mem_rdata;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    // Abort leaves rdata untouched; the owner sees done together with err.
                    state_d = IDLE;
                    err_d   = 1'b1;
                    if (owner_q == SIDE_D) d_done_d = 1'b1;
                    else                   i_done_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Starvation counter: counts D grants that overtook a waiting I request.
    always_comb begin
        starve_d = starve_q;
        if (!bus.i_req || i_gnt_d) begin
            starve_d = '0;
        end else if (d_gnt_d && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + SC_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            owner_q   <= SIDE_I;
            rr_last_q <= SIDE_I;
            starve_q  <= '0;
            wait_q    <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            i_gnt_q   <= 1'b0;
            d_gnt_q   <= 1'b0;
            i_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
            err_q     <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_last_q <= rr_last_d;
            starve_q  <= starve_d;
            wait_q    <= wait_d;
            i_gnt_q   <= i_gnt_d;
            d_gnt_q   <= d_gnt_d;
            i_done_q  <= i_done_d;
            d_done_q  <= d_done_d;
            err_q     <= err_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            if (latch_en) begin
                we_q    <= lat_we;
                addr_q  <= lat_addr;
                wdata_q <= lat_wdata;
            end
        end
    end

    assign bus.i_gnt     = i_gnt_q;
    assign bus.d_gnt     = d_gnt_q;
    assign bus.i_done    = i_done_q;
    assign bus.d_done    = d_done_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.mem_req   = (state_q == REQ);
    assign bus.mem_we    = (state_q == REQ) && we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign busy          = (state_q != IDLE);
    assign err           = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one fixed-priority instance and one round-robin instance.
module tb_mem_port_arbiter;

    logic clock;
    logic reset;
    logic busy_p, err_p, busy_r, err_r;

    int errors = 0;
    int checks = 0;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bp ();
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) br ();

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .D_PRIORITY(1), .STARVE_LIM(4), .TIMEOUT(15)
    ) dut_p (
        .clock (clock),
        .reset (reset),
        .bus   (bp),
        .busy  (busy_p),
        .err   (err_p)
    );

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .D_PRIORITY(0), .STARVE_LIM(4), .TIMEOUT(15)
    ) dut_r (
        .clock (clock),
        .reset (reset),
        .bus   (br),
        .busy  (busy_r),
        .err   (err_r)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Records up to 'want' grants (bit k = 1 for D, 0 for I) within a bounded cycle budget.
    task automatic collect(input bit on_r, input int want, output logic [7:0] seq, output int got);
        logic ig, dg;
        seq = '0;
        got = 0;
        for (int c = 0; c < 100 && got < want; c++) begin
            @(negedge clock);
            ig = on_r ? br.i_gnt : bp.i_gnt;
            dg = on_r ? br.d_gnt : bp.d_gnt;
            if (dg) begin
                seq[got] = 1'b1;
                got++;
            end else if (ig) begin
                seq[got] = 1'b0;
                got++;
            end
        end
    endtask

    initial begin
        logic [7:0] seq;
        int         got;
        int         n;
        logic       seen;

        reset = 1'b0;
        bp.i_req = 1'b0; bp.i_addr = '0;
        bp.d_req = 1'b0; bp.d_we = 1'b0; bp.d_addr = '0; bp.d_wdata = '0;
        bp.mem_ready = 1'b0; bp.mem_rvalid = 1'b0; bp.mem_rdata = '0;
        br.i_req = 1'b0; br.i_addr = '0;
        br.d_req = 1'b0; br.d_we = 1'b0; br.d_addr = '0; br.d_wdata = '0;
        // Round-robin instance sees a zero-wait memory throughout.
        br.mem_ready = 1'b1; br.mem_rvalid = 1'b1; br.mem_rdata = 32'hA5A5_0000;

        // Reset state
        repeat (2) @(negedge clock);
        chk("rst_ctrl", {busy_p, err_p, bp.i_gnt, bp.d_gnt, bp.i_done, bp.d_done,
                         bp.mem_req, bp.mem_we}, 8'h00);
        chk("rst_addr", bp.mem_addr, 0);
        chk("rst_wdata", bp.mem_wdata, 0);
        chk("rst_rdata", {bp.i_rdata, bp.d_rdata}, 0);
        chk("rst_rr_ctrl", {busy_r, err_r, br.i_gnt, br.d_gnt, br.mem_req}, 5'b0);
        reset = 1'b1;
        @(negedge clock);

        // I-side read, memory ready at once, read data two cycles after the request
        bp.i_req = 1'b1; bp.i_addr = 32'h40; bp.mem_ready = 1'b1;
        @(negedge clock);
        chk("rd_gnt", {bp.i_gnt, bp.d_gnt}, 2'b10);
        chk("rd_mem_req", {bp.mem_req, bp.mem_we}, 2'b10);
        chk("rd_mem_addr", bp.mem_addr, 32'h40);
        bp.i_req = 1'b0;
        @(negedge clock);
        chk("rd_resp", {busy_p, bp.mem_req, bp.i_done, bp.i_gnt}, 4'b1000);
        bp.mem_ready = 1'b0; bp.mem_rvalid = 1'b1; bp.mem_rdata = 32'hDEAD_BEEF;
        @(negedge clock);
        chk("rd_done", {bp.i_done, bp.d_done, busy_p}, 3'b100);
        chk("rd_rdata", bp.i_rdata, 32'hDEAD_BEEF);
        bp.mem_rvalid = 1'b0; bp.mem_rdata = '0;
        @(negedge clock);
        chk("rd_done_once", bp.i_done, 1'b0);
        chk("rd_rdata_hold", bp.i_rdata, 32'hDEAD_BEEF);

        // Simultaneous requests with D priority: D store first, then I read
        bp.i_req = 1'b1; bp.i_addr = 32'h80;
        bp.d_req = 1'b1; bp.d_we = 1'b1; bp.d_addr = 32'h10; bp.d_wdata = 32'h1234;
        bp.mem_ready = 1'b1;
        @(negedge clock);
        chk("pri_dgnt", {bp.d_gnt, bp.i_gnt}, 2'b10);
        chk("pri_mem_we", {bp.mem_req, bp.mem_we}, 2'b11);
        chk("pri_mem_addr", bp.mem_addr, 32'h10);
        chk("pri_mem_wdata", bp.mem_wdata, 32'h1234);
        bp.d_req = 1'b0; bp.d_we = 1'b0;
        @(negedge clock);
        chk("pri_ddone", {bp.d_done, bp.i_gnt, bp.i_done, busy_p}, 4'b1000);
        chk("pri_store_keeps_drdata", bp.d_rdata, 0);
        bp.mem_rvalid = 1'b1; bp.mem_rdata = 32'h0BAD_F00D;
        @(negedge clock);
        chk("pri_ignt", {bp.i_gnt, bp.d_done, bp.mem_we}, 3'b100);
        chk("pri_i_addr", bp.mem_addr, 32'h80);
        bp.i_req = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk("pri_idone", {bp.i_done, bp.d_done}, 2'b10);
        chk("pri_irdata", bp.i_rdata, 32'h0BAD_F00D);

        // Starvation limit: both held -> D,D,D,D,I,D
        bp.i_req = 1'b1; bp.i_addr = 32'hC0;
        bp.d_req = 1'b1; bp.d_we = 1'b1; bp.d_addr = 32'h14; bp.d_wdata = 32'h55;
        collect(1'b0, 6, seq, got);
        bp.i_req = 1'b0; bp.d_req = 1'b0; bp.d_we = 1'b0;
        chk("starve_count", got, 6);
        chk("starve_order", seq[5:0], 6'b101111);
        repeat (4) @(negedge clock);

        // Round robin: both held -> D,I,D,I starting from the reset value of rr_last
        br.i_req = 1'b1; br.i_addr = 32'h100;
        br.d_req = 1'b1; br.d_we = 1'b1; br.d_addr = 32'h30; br.d_wdata = 32'h77;
        collect(1'b1, 4, seq, got);
        br.i_req = 1'b0; br.d_req = 1'b0; br.d_we = 1'b0;
        chk("rr_count", got, 4);
        chk("rr_order", seq[3:0], 4'b0101);
        repeat (4) @(negedge clock);

        // Timeout: D load, memory never accepts
        bp.mem_ready = 1'b0; bp.mem_rvalid = 1'b0;
        bp.d_req = 1'b1; bp.d_we = 1'b0; bp.d_addr = 32'h20;
        @(negedge clock);
        chk("to_gnt", {bp.d_gnt, bp.mem_req}, 2'b11);
        bp.d_req = 1'b0;
        n = 0;
        while (n < 30 && !err_p) begin
            @(negedge clock);
            n++;
        end
        chk("to_delay", n, 15);
        chk("to_abort", {err_p, bp.d_done, bp.i_done, bp.mem_req, busy_p}, 5'b11000);
        chk("to_rdata_kept", bp.d_rdata, 0);
        @(negedge clock);
        chk("to_pulse", {err_p, bp.d_done}, 2'b00);
        bp.mem_ready = 1'b1; bp.mem_rvalid = 1'b1; bp.mem_rdata = 32'h1111_2222;
        bp.i_req = 1'b1; bp.i_addr = 32'h48;
        @(negedge clock);
        chk("to_next_ignt", {bp.i_gnt, bp.mem_req}, 2'b11);
        chk("to_next_addr", bp.mem_addr, 32'h48);
        bp.i_req = 1'b0;
        repeat (3) @(negedge clock);

        // Reset in the middle of a read (RESP state)
        bp.mem_ready = 1'b1; bp.mem_rvalid = 1'b0;
        bp.i_req = 1'b1; bp.i_addr = 32'h44;
        @(negedge clock);
        chk("mr_gnt", bp.i_gnt, 1'b1);
        bp.i_req = 1'b0;
        @(negedge clock);
        chk("mr_resp", {busy_p, bp.mem_req}, 2'b10);
        reset = 1'b0;
        @(negedge clock);
        chk("mr_ctrl", {busy_p, err_p, bp.i_gnt, bp.d_gnt, bp.i_done, bp.d_done,
                        bp.mem_req, bp.mem_we}, 8'h00);
        chk("mr_addr", bp.mem_addr, 0);
        chk("mr_rdata", bp.i_rdata, 0);
        bp.mem_rvalid = 1'b1; bp.mem_rdata = 32'h9999_9999;
        reset = 1'b1;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clock);
            seen = seen | bp.i_done | busy_p;
        end
        chk("mr_no_done", seen, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
